mesh_term_ingress: RTL and testbench

- Terminal-side ingress buffer bank for the parametrised mesh (mesh_gnrtr).
- Holds one first-word-fall-through FIFO per mesh terminal and drives that terminal's pndng_i_in/data_out_i_in.
- Pops on the mesh's popin.
- Generalises the single fixed-depth bench-model FIFO: any terminal count and depth, plus almost-full, per-terminal enable/flush, saturating drop counters and a sticky underflow flag.

---
 rtl/mesh_term_pkg.sv | 20 ++
 rtl/mesh_term_fifo.sv | 87 ++++++++
 rtl/mesh_term_ingress.sv | 53 +++++
 tb/tb_mesh_term_ingress.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mesh_term_pkg.sv
// Shared helpers for the mesh terminal ingress bank: counter widths,
// pointer widths and flattened-bus slice offsets.
package mesh_term_pkg;

  localparam int DROP_W_DEF = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Low bit of lane idx in a flattened bus of w-bit lanes.
  function automatic int sl_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Single-terminal FWFT FIFO: occupancy count, flush, saturating drop
// counter and sticky underflow flag.
module mesh_term_fifo
  import mesh_term_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int W      = 32,
  parameter int AF     = 12,
  parameter int DROP_W = DROP_W_DEF,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [W-1:0]      data_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              pop_i,
  output logic              pndng_o,
  output logic [W-1:0]      data_o,
  output logic              full_o,
  output logic              afull_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              underflow_o
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [DROP_W-1:0] DROP_SAT = '1;

  logic [W-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr, r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [DROP_W-1:0] r_drop;
  logic              r_udf;

  logic w_empty, w_full, w_pndng, w_pop, w_wr, w_drop;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_pndng = enable_i & ~w_empty;
  assign w_pop   = pop_i & w_pndng;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr    = push_i & (~w_full | w_pop);
  assign w_drop  = push_i & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && w_wr) r_mem[r_wr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
      r_udf  <= 1'b0;
    end else begin
      if (pop_i && !w_pndng) r_udf <= 1'b1;
      if (flush_i) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_wr)  r_wr <= f_inc(r_wr);
        if (w_pop) r_rd <= f_inc(r_rd);
        if (w_wr && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
        else if (w_pop && !w_wr) r_cnt <= r_cnt - CNT_W'(1);
        if (w_drop && r_drop != DROP_SAT) r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  assign pndng_o     = w_pndng;
  assign data_o      = w_empty ? '0 : r_mem[r_rd];
  assign full_o      = w_full;
  assign afull_o     = (r_cnt >= CNT_W'(AF));
  assign count_o     = r_cnt;
  assign drop_cnt_o  = r_drop;
  assign underflow_o = r_udf;

endmodule

// File: rtl/mesh_term_ingress.sv
// Terminal-side ingress buffer bank: one independent FWFT FIFO per mesh
// terminal, feeding pndng_i_in/data_out_i_in and popped by popin.
module mesh_term_ingress
  import mesh_term_pkg::*;
#(
  parameter int NUM_TERMS  = 16,
  parameter int PAKG_SIZE  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = 12,
  parameter int DROP_W     = 16,
  localparam int CNT_W     = cnt_w(FIFO_DEPTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_TERMS-1:0]          push_i,
  input  logic [NUM_TERMS*PAKG_SIZE-1:0] data_in_i,
  input  logic [NUM_TERMS-1:0]          enable_i,
  input  logic [NUM_TERMS-1:0]          flush_i,
  input  logic [NUM_TERMS-1:0]          popin_i,
  output logic [NUM_TERMS-1:0]          pndng_i_in_o,
  output logic [NUM_TERMS*PAKG_SIZE-1:0] data_out_i_in_o,
  output logic [NUM_TERMS-1:0]          full_o,
  output logic [NUM_TERMS-1:0]          almost_full_o,
  output logic [NUM_TERMS*CNT_W-1:0]    count_o,
  output logic [NUM_TERMS*DROP_W-1:0]   drop_cnt_o,
  output logic [NUM_TERMS-1:0]          underflow_o
);

  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    mesh_term_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .W      (PAKG_SIZE),
      .AF     (AF_LEVEL),
      .DROP_W (DROP_W)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_i[t]),
      .data_i      (data_in_i[sl_lo(t, PAKG_SIZE) +: PAKG_SIZE]),
      .enable_i    (enable_i[t]),
      .flush_i     (flush_i[t]),
      .pop_i       (popin_i[t]),
      .pndng_o     (pndng_i_in_o[t]),
      .data_o      (data_out_i_in_o[sl_lo(t, PAKG_SIZE) +: PAKG_SIZE]),
      .full_o      (full_o[t]),
      .afull_o     (almost_full_o[t]),
      .count_o     (count_o[sl_lo(t, CNT_W) +: CNT_W]),
      .drop_cnt_o  (drop_cnt_o[sl_lo(t, DROP_W) +: DROP_W]),
      .underflow_o (underflow_o[t])
    );
  end

endmodule

// File: tb/tb_mesh_term_ingress.sv
// Directed scoreboard bench for mesh_term_ingress: a 16x16 bank and a
// 4-terminal depth-5 bank for pointer wrap.
module tb_mesh_term_ingress;

  localparam int NT = 16, PW = 32, D = 16, CW = 5, DW = 16;
  localparam int NT5 = 4, D5 = 5, CW5 = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NT-1:0]      push, en, flush, popin;
  logic [NT*PW-1:0]   din;
  logic [NT-1:0]      pndng, full, af, udf;
  logic [NT*PW-1:0]   dout;
  logic [NT*CW-1:0]   cnt;
  logic [NT*DW-1:0]   drop;

  logic [NT5-1:0]     p5_push, p5_en, p5_flush, p5_pop;
  logic [NT5*PW-1:0]  p5_din;
  logic [NT5-1:0]     p5_pndng, p5_full, p5_af, p5_udf;
  logic [NT5*PW-1:0]  p5_dout;
  logic [NT5*CW5-1:0] p5_cnt;
  logic [NT5*DW-1:0]  p5_drop;

  int n_chk = 0, n_err = 0;
  int mcnt, mdrop;
  logic [31:0] sb[$];
  logic [31:0] q5[$];

  always #5 clk = ~clk;

  mesh_term_ingress #(.NUM_TERMS(NT), .PAKG_SIZE(PW), .FIFO_DEPTH(D), .AF_LEVEL(12), .DROP_W(DW)) u_dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .data_in_i(din), .enable_i(en),
    .flush_i(flush), .popin_i(popin), .pndng_i_in_o(pndng), .data_out_i_in_o(dout),
    .full_o(full), .almost_full_o(af), .count_o(cnt), .drop_cnt_o(drop), .underflow_o(udf));

  mesh_term_ingress #(.NUM_TERMS(NT5), .PAKG_SIZE(PW), .FIFO_DEPTH(D5), .AF_LEVEL(4), .DROP_W(DW)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .push_i(p5_push), .data_in_i(p5_din), .enable_i(p5_en),
    .flush_i(p5_flush), .popin_i(p5_pop), .pndng_i_in_o(p5_pndng), .data_out_i_in_o(p5_dout),
    .full_o(p5_full), .almost_full_o(p5_af), .count_o(p5_cnt), .drop_cnt_o(p5_drop), .underflow_o(p5_udf));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock on terminal t of the main bank, with the model updated and
  // the popped head compared against the scoreboard.
  task automatic step(input int t);
    bit epop, acc;
    epop = popin[t] && en[t] && (mcnt > 0);
    if (epop) begin
      if (sb.size() == 0) chk($sformatf("t%0d sb underrun", t), 1, 0);
      else chk($sformatf("t%0d head", t), dout[t*PW +: PW], sb.pop_front());
    end
    acc = push[t] && ((mcnt < D) || epop);
    if (acc) sb.push_back(din[t*PW +: PW]);
    else if (push[t] && mdrop < 65535) mdrop++;
    if (acc && !epop) mcnt++;
    else if (epop && !acc) mcnt--;
    tick();
    chk($sformatf("t%0d count", t), cnt[t*CW +: CW], mcnt);
    chk($sformatf("t%0d drop", t), drop[t*DW +: DW], mdrop);
    chk($sformatf("t%0d full", t), full[t], mcnt == D);
    chk($sformatf("t%0d afull", t), af[t], mcnt >= 12);
    chk($sformatf("t%0d pndng", t), pndng[t], en[t] && mcnt > 0);
  endtask

  task automatic drain(input int t);
    int n = 0;
    popin[t] = 1'b1;
    while (sb.size() > 0 && n < 40) begin step(t); n++; end
    popin[t] = 1'b0;
    chk($sformatf("t%0d drain done", t), sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; push = '0; en = '1; flush = '0; popin = '0; din = '0;
    p5_push = '0; p5_en = '1; p5_flush = '0; p5_pop = '0; p5_din = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst pndng", pndng, 0);
    chk("rst full", full, 0);
    chk("rst afull", af, 0);
    chk("rst count", cnt, 0);
    chk("rst drop lo", drop[63:0], 0);
    chk("rst udf", udf, 0);
    chk("rst dout lo", dout[63:0], 0);
    for (int i = 0; i < 20; i++) begin tick(); chk("idle pndng", pndng, 0); end

    // Terminal 3: stream through with popin held high.
    mcnt = 0; mdrop = 0;
    popin[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push[3] = 1'b1; din[3*PW +: PW] = 32'hA5A5_0001 + k;
      step(3);
      if (k == 0) chk("t3 pndng rise", pndng[3], 1);
    end
    push[3] = 1'b0;
    drain(3);
    chk("t3 count end", cnt[3*CW +: CW], 0);

    // Terminal 0: overfill by two, then drain.
    mcnt = 0; mdrop = 0;
    for (int i = 0; i < 18; i++) begin
      push[0] = 1'b1; din[0 +: PW] = 32'h0000_1000 + i;
      step(0);
    end
    push[0] = 1'b0;
    chk("t0 full", full[0], 1);
    chk("t0 drop2", drop[0 +: DW], 2);
    drain(0);

    // Terminal 5: push while full with a simultaneous pop.
    mcnt = 0; mdrop = 0;
    for (int i = 0; i < 16; i++) begin
      push[5] = 1'b1; din[5*PW +: PW] = 32'h0000_5000 + i;
      step(5);
    end
    din[5*PW +: PW] = 32'h55; popin[5] = 1'b1;
    step(5);
    push[5] = 1'b0; popin[5] = 1'b0;
    chk("t5 count16", cnt[5*CW +: CW], 16);
    chk("t5 drop0", drop[5*DW +: DW], 0);
    drain(5);

    // Terminal 7: disabled pop underflows; flush beats push.
    mcnt = 0; mdrop = 0;
    for (int i = 0; i < 4; i++) begin
      push[7] = 1'b1; din[7*PW +: PW] = 32'h0000_7000 + i;
      step(7);
    end
    push[7] = 1'b0; en[7] = 1'b0; popin[7] = 1'b1;
    step(7);
    popin[7] = 1'b0;
    chk("t7 udf", udf[7], 1);
    chk("t7 count4", cnt[7*CW +: CW], 4);
    flush[7] = 1'b1; push[7] = 1'b1; din[7*PW +: PW] = 32'hDEAD_BEEF;
    tick();
    flush[7] = 1'b0; push[7] = 1'b0; en[7] = 1'b1;
    chk("t7 flush count", cnt[7*CW +: CW], 0);
    chk("t7 flush drop", drop[7*DW +: DW], 0);
    chk("t7 flush pndng", pndng[7], 0);
    chk("t7 udf kept", udf[7], 1);
    sb.delete();

    // Mid-stream reset with 6 queued on terminal 2.
    mcnt = 0; mdrop = 0;
    for (int i = 0; i < 6; i++) begin
      push[2] = 1'b1; din[2*PW +: PW] = 32'h0000_2000 + i;
      step(2);
    end
    rst = 1'b1; popin[2] = 1'b1;
    tick();
    rst = 1'b0; push[2] = 1'b0; popin[2] = 1'b0;
    chk("mrst pndng", pndng[2], 0);
    chk("mrst count", cnt[2*CW +: CW], 0);
    chk("mrst udf", udf, 0);
    chk("mrst drop t0", drop[0 +: DW], 0);
    sb.delete();

    // Depth-5 bank, terminal 1: three fill/drain rounds across the wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        p5_push[1] = 1'b1; p5_din[PW +: PW] = 32'h0000_7700 + r*16 + i;
        if (i < 5) q5.push_back(p5_din[PW +: PW]);
        tick();
        chk("d5 count", p5_cnt[CW5 +: CW5], (i < 5) ? i + 1 : 5);
        chk("d5 full", p5_full[1], i >= 4);
        chk("d5 afull", p5_af[1], i >= 3);
      end
      p5_push[1] = 1'b0;
      chk("d5 drop", p5_drop[DW +: DW], r + 1);
      p5_pop[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
        chk("d5 pndng", p5_pndng[1], 1);
        chk("d5 head", p5_dout[PW +: PW], q5.pop_front());
        tick();
      end
      p5_pop[1] = 1'b0;
      chk("d5 empty", p5_cnt[CW5 +: CW5], 0);
      chk("d5 udf", p5_udf[1], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
